// File: rtl/fifo_lector_pkg.sv
// Shared definitions for the FIFO read-side controller: FSM state
// encodings, skid-buffer geometry, default widths and the pop-room check.
package fifo_lector_pkg;

  // Reader FSM states, 2-bit encoded
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // Skid buffer depth; it must cover the one-cycle FIFO read latency plus
  // the word the consumer may be refusing.
  localparam int SKID_DEPTH = 2;

  // Width of the skid occupancy counter (holds 0..SKID_DEPTH)
  localparam int SKID_CW = $clog2(SKID_DEPTH + 1);

  // Default data and delivered-word counter widths
  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_CW = 16;

  // True when one more pop still fits: words held in the skid plus the
  // word in flight, minus the word leaving this cycle, must stay below
  // the skid depth. Written as occ < depth + accept so it never
  // underflows.
  function automatic logic pop_room(input logic [SKID_CW-1:0] skid_cnt,
                                    input logic               inflight,
                                    input logic               accept);
    logic [SKID_CW:0] occ;
    logic [SKID_CW:0] limit;
    occ   = {1'b0, skid_cnt} + {{SKID_CW{1'b0}}, inflight};
    limit = (SKID_CW + 1)'(SKID_DEPTH) + {{SKID_CW{1'b0}}, accept};
    return (occ < limit);
  endfunction

endpackage

// File: rtl/fifo_skid.sv
// fifo_skid: small register-based FIFO that absorbs the read latency of
// the upstream FIFO. Entry 0 is always the head; a read shifts every entry
// one place toward the head, and a write lands in the first free slot
// after that shift, so a simultaneous write and read keeps order.
module fifo_skid
  import fifo_lector_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr,
  input  logic [DW-1:0]      i_wr_data,
  input  logic               i_rd,
  output logic [DW-1:0]      o_head,
  output logic [SKID_CW-1:0] o_count
);

  logic [DW-1:0]      r_mem [SKID_DEPTH];
  logic [DW-1:0]      w_mem_next [SKID_DEPTH];
  logic [SKID_CW-1:0] r_count;
  logic [SKID_CW-1:0] w_wr_idx;

  // Slot the incoming word lands in, after any head pop this cycle
  assign w_wr_idx = r_count - SKID_CW'(i_rd);

  // Per-entry next value: write wins, else shift from the entry behind
  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      if (gi < SKID_DEPTH - 1) begin : g_shift
        assign w_mem_next[gi] = (i_wr && (w_wr_idx == SKID_CW'(gi))) ? i_wr_data :
                                i_rd                                  ? r_mem[gi + 1] :
                                                                        r_mem[gi];
      end else begin : g_tail
        assign w_mem_next[gi] = (i_wr && (w_wr_idx == SKID_CW'(gi))) ? i_wr_data :
                                                                        r_mem[gi];
      end
    end
  endgenerate

  // Storage update; contents clear to zero so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= w_mem_next[i];
      end
    end
  end

  // Occupancy tracks writes in and reads out
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + SKID_CW'(i_wr) - SKID_CW'(i_rd);
    end
  end

  assign o_head  = r_mem[0];
  assign o_count = r_count;

endmodule

// File: rtl/fifo_lector.sv
// fifo_lector: read-side controller for the synchronous FIFO. Issues pops,
// catches the returning words in a 2-entry skid buffer and hands them to a
// valid/ready consumer at full rate. Unrequested read data or a FIFO error
// lock the reader in ERR until reset.
module fifo_lector
  import fifo_lector_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] fifo_data_out,
  input  logic          fifo_valid_out,
  input  logic          fifo_empty,
  input  logic          fifo_error,
  output logic          pop,
  output logic [DW-1:0] dn_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] word_count
);

  state_t             r_state;
  logic               r_inflight;
  logic               r_err;
  logic               r_rst_d;
  logic [CW-1:0]      r_word_count;

  logic [SKID_CW-1:0] w_skid_count;
  logic [DW-1:0]      w_skid_head;
  logic               w_frozen;
  logic               w_skid_empty;
  logic               w_accept;
  logic               w_pop;
  logic               w_stray;
  logic               w_err_event;
  logic               w_skid_wr;

  assign w_frozen     = (r_state == ST_ERR);
  assign w_skid_empty = (w_skid_count == '0);

  // Consumer side: head is offered whenever something is buffered
  assign dn_valid = !w_skid_empty && !w_frozen;
  assign dn_data  = w_skid_head;
  assign w_accept = dn_valid && dn_ready;

  // Pop looks through dn_ready so a word leaving this cycle frees room
  // for a new pop in the same cycle. Gated by reset so nothing is requested
  // while the reader is being cleared.
  assign w_pop = (r_state == ST_RUN) && !reset && !fifo_empty &&
                 pop_room(w_skid_count, r_inflight, w_accept);
  assign pop   = w_pop;

  // Read data nobody asked for. The cycle right after reset is excused:
  // a pop issued before reset may still be answered then.
  assign w_stray     = fifo_valid_out && !r_inflight && !r_rst_d;
  assign w_err_event = !w_frozen && (w_stray || fifo_error);

  // Only requested data enters the skid, and nothing moves once in ERR
  assign w_skid_wr = fifo_valid_out && r_inflight && !w_frozen;

  fifo_skid #(
    .DW (DW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .i_wr      (w_skid_wr),
    .i_wr_data (fifo_data_out),
    .i_rd      (w_accept),
    .o_head    (w_skid_head),
    .o_count   (w_skid_count)
  );

  // Reader FSM with the sticky error flag; error events override all
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else if (w_err_event) begin
      r_state <= ST_ERR;
      r_err   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (enable) begin
            r_state <= ST_RUN;
          end else if (!r_inflight && w_skid_empty) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
      endcase
    end
  end

  // Remember whether a pop is awaiting its data next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
    end
  end

  // One-cycle echo of reset, used to excuse late read data
  always_ff @(posedge clk) begin
    r_rst_d <= reset;
  end

  // Delivered-word counter, wraps naturally at 2^CW
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_count <= '0;
    end else if (w_accept) begin
      r_word_count <= r_word_count + 1'b1;
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_lector.sv
// Bench for fifo_lector: a queue-based FIFO model feeds the reader, a
// scoreboard queue holds the words that must come out, and an independent
// monitor checks every handshake, the word counter and the outstanding
// limit. Directed phases cover reset, streaming, backpressure, drain,
// errors and reset mid-stream; a random phase mixes enable, dn_ready and
// pushes.
module tb_fifo_lector;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_valid_out;
  logic          fifo_empty;
  logic          fifo_error;
  logic          pop;
  logic [DW-1:0] dn_data;
  logic          dn_valid;
  logic          dn_ready;
  logic          busy;
  logic          err;
  logic [CW-1:0] word_count;

  fifo_lector #(
    .DW (DW),
    .CW (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fifo_data_out  (fifo_data_out),
    .fifo_valid_out (fifo_valid_out),
    .fifo_empty     (fifo_empty),
    .fifo_error     (fifo_error),
    .pop            (pop),
    .dn_data        (dn_data),
    .dn_valid       (dn_valid),
    .dn_ready       (dn_ready),
    .busy           (busy),
    .err            (err),
    .word_count     (word_count)
  );

  always #5 clk = ~clk;

  int            n_tests   = 0;
  int            n_fail    = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_total = 0;
  bit            mon_en    = 1'b0;
  int            popped    = 0;
  int            accepted  = 0;
  bit            pop_s     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Observe pop on the falling edge, where everything has settled
  task automatic sample();
    @(negedge clk);
    pop_s = pop;
  endtask

  // FIFO model: a pop seen this cycle returns its word on the next one
  task automatic advance();
    @(posedge clk);
    #1;
    fifo_error = 1'b0;
    if (pop_s && fifo_q.size() > 0) begin
      fifo_valid_out = 1'b1;
      fifo_data_out  = fifo_q.pop_front();
    end else begin
      fifo_valid_out = 1'b0;
      fifo_data_out  = DW'($urandom);
    end
    fifo_empty = (fifo_q.size() == 0);
    pop_s      = 1'b0;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic load_seq(input logic [DW-1:0] base, input int n, input bit expect_out);
    for (int k = 0; k < n; k++) begin
      fifo_q.push_back(base + DW'(k));
      if (expect_out) begin
        exp_q.push_back(base + DW'(k));
        exp_total++;
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic flush_model();
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    popped     = 0;
    accepted   = 0;
    exp_total  = 0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      done = !busy;
      advance();
      if (done) break;
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Monitor: scoreboard on every handshake plus running invariants
  initial begin
    logic [DW-1:0] exp_word;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pop && fifo_empty) check("pop_while_empty", 32'(pop), 32'd0);
        check("word_count_track", 32'(word_count), 32'(CW'(accepted)));
        check("outstanding_le_2", 32'((popped - accepted) <= 2), 32'd1);
        if (dn_valid && dn_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_word", 32'(dn_data), 32'hFFFF_FFFF);
          end else begin
            exp_word = exp_q.pop_front();
            check("deliver_data", 32'(dn_data), 32'(exp_word));
          end
          accepted++;
          $display("[TB] deliver 0x%02h (word %0d)", dn_data, accepted);
        end
        if (pop) popped++;
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    bit            acc;
    bit            found;

    reset          = 1'b1;
    enable         = 1'b0;
    dn_ready       = 1'b0;
    fifo_valid_out = 1'b0;
    fifo_error     = 1'b0;
    fifo_empty     = 1'b1;
    fifo_data_out  = '0;

    // ---- Reset with random inputs ----
    repeat (2) begin
      enable         = 1'($urandom);
      dn_ready       = 1'($urandom);
      fifo_valid_out = 1'($urandom);
      fifo_error     = 1'($urandom);
      fifo_empty     = 1'($urandom);
      fifo_data_out  = DW'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_pop",        32'(pop),        32'd0);
    check("rst_dn_valid",   32'(dn_valid),   32'd0);
    check("rst_dn_data",    32'(dn_data),    32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_err",        32'(err),        32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    reset          = 1'b0;
    enable         = 1'b0;
    dn_ready       = 1'b0;
    fifo_valid_out = 1'b0;
    fifo_error     = 1'b0;
    flush_model();
    mon_en = 1'b1;

    // ---- Streaming: 8 words at full rate ----
    load_seq(8'h10, 8, 1'b1);
    enable   = 1'b1;
    dn_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sample();
      check($sformatf("stream_pop_c%0d", i), 32'(pop), 32'(i >= 1 && i <= 8));
      check($sformatf("stream_valid_c%0d", i), 32'(dn_valid), 32'(i >= 3 && i <= 10));
      if (i >= 3 && i <= 10) check($sformatf("stream_data_c%0d", i), 32'(dn_data), 32'(8'h10 + i - 3));
      if (i == 0) check("stream_busy_c0", 32'(busy), 32'd0);
      advance();
    end
    check("stream_count", 32'(word_count), 32'(exp_total));
    enable = 1'b0;
    wait_idle("stream_idle");

    // ---- Backpressure: stall 5 cycles after the first word ----
    load_seq(8'h10, 8, 1'b1);
    enable   = 1'b1;
    dn_ready = 1'b1;
    found    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      acc = dn_valid && dn_ready;
      advance();
      if (acc) begin
        found = 1'b1;
        break;
      end
    end
    check("bp_first_word", 32'(found), 32'd1);
    dn_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      check($sformatf("bp_stall_pop_%0d", k), 32'(pop), 32'd0);
      if (k == 4) begin
        check("bp_held_words", 32'(popped - accepted), 32'd2);
        check("bp_head_valid", 32'(dn_valid), 32'd1);
      end
      advance();
    end
    dn_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) step();
    check("bp_all_delivered", 32'(exp_q.size()), 32'd0);
    check("bp_count", 32'(word_count), 32'(exp_total));
    enable = 1'b0;
    wait_idle("bp_idle");

    // ---- Drain: enable drops while a pop is issued ----
    load_seq(8'h40, 8, 1'b1);
    enable   = 1'b1;
    dn_ready = 1'b1;
    repeat (3) step();
    enable = 1'b0;
    sample();
    check("drain_pop_at_fall", 32'(pop), 32'd1);
    advance();
    for (int k = 0; k < 8; k++) begin
      sample();
      check($sformatf("drain_no_pop_%0d", k), 32'(pop), 32'd0);
      if (k == 7) check("drain_busy_low", 32'(busy), 32'd0);
      advance();
    end
    check("drain_left_in_fifo", 32'(fifo_q.size()), 32'd5);
    check("drain_undelivered", 32'(exp_q.size()), 32'd5);
    exp_total = exp_total - 5;
    check("drain_count", 32'(word_count), 32'(exp_total));
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;

    // ---- Random traffic ----
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) begin
        w = DW'($urandom);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        exp_total++;
        fifo_empty = 1'b0;
      end
      enable   = ($urandom_range(0, 9) != 0);
      dn_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    enable   = 1'b1;
    dn_ready = 1'b1;
    for (int k = 0; k < 80 && exp_q.size() > 0; k++) step();
    check("rand_all_delivered", 32'(exp_q.size()), 32'd0);
    check("rand_count", 32'(word_count), 32'(CW'(exp_total)));
    enable = 1'b0;
    wait_idle("rand_idle");

    // ---- Error events: stray read data, then FIFO error ----
    for (int e = 0; e < 2; e++) begin
      if (e == 0) fifo_valid_out = 1'b1;
      else        fifo_error     = 1'b1;
      step();
      load_seq(8'h80, 4, 1'b0);
      enable   = 1'b1;
      dn_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
        sample();
        check($sformatf("err%0d_flag_%0d", e, k),  32'(err),        32'd1);
        check($sformatf("err%0d_pop_%0d", e, k),   32'(pop),        32'd0);
        check($sformatf("err%0d_valid_%0d", e, k), 32'(dn_valid),   32'd0);
        check($sformatf("err%0d_count_%0d", e, k), 32'(word_count), 32'(CW'(exp_total)));
        advance();
      end
      mon_en = 1'b0;
      reset  = 1'b1;
      enable = 1'b0;
      step();
      reset = 1'b0;
      flush_model();
      mon_en = 1'b1;
      sample();
      check($sformatf("err%0d_cleared", e), 32'(err),        32'd0);
      check($sformatf("err%0d_busy", e),    32'(busy),       32'd0);
      check($sformatf("err%0d_wc", e),      32'(word_count), 32'd0);
      advance();
    end

    // ---- Reset mid-stream with a word in the skid and one in flight ----
    load_seq(8'hA0, 8, 1'b1);
    enable   = 1'b1;
    dn_ready = 1'b0;
    step();
    step();
    sample();
    check("mid_pop_in_flight", 32'(pop), 32'd1);
    advance();
    mon_en = 1'b0;
    reset  = 1'b1;
    sample();
    check("mid_skid_loaded", 32'(dn_valid), 32'd1);
    advance();
    reset = 1'b0;
    flush_model();
    mon_en         = 1'b1;
    fifo_valid_out = 1'b1;
    fifo_data_out  = 8'hEE;
    sample();
    check("mid_valid_cleared", 32'(dn_valid),   32'd0);
    check("mid_wc_cleared",    32'(word_count), 32'd0);
    check("mid_err_clear",     32'(err),        32'd0);
    advance();
    for (int k = 0; k < 3; k++) begin
      sample();
      check($sformatf("mid_late_ignored_%0d", k), 32'(err),      32'd0);
      check($sformatf("mid_no_word_%0d", k),      32'(dn_valid), 32'd0);
      advance();
    end
    enable = 1'b0;
    wait_idle("mid_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
